// File: rtl/controller_interface.sv
// Polls two NES-style serial controllers over a shared clock/latch pair and
// exposes the decoded button bytes as two read-only CPU registers.
module controller_interface #(
    parameter int          TICK_DIV   = 12,
    parameter logic [15:0] CTRL1_ADDR = 16'h7002,
    parameter logic [15:0] CTRL2_ADDR = 16'h7003
) (
    input  logic        clk_12_5875,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cpu_address,
    input  logic        write_enable_B,
    output logic [7:0]  data_out,
    output logic        fpga_data_enable,
    output logic        controller_clk,
    output logic        controller_latch,
    input  logic        controller_1_data_in_B,
    input  logic        controller_2_data_in_B,
    output logic [7:0]  controller_1_data_out,
    output logic [7:0]  controller_2_data_out,
    output logic        busy
);

    // state     | meaning
    // S_IDLE    | waiting for start
    // S_LATCH   | latch high for one tick, controllers load buttons
    // S_SAMPLE7 | latch low; first serial bit sampled at end of tick
    // S_CLK_HI  | controller_clk high; bit bit_q sampled at end of tick
    // S_CLK_LO  | controller_clk low for one tick
    // S_COMMIT  | one clock: shift registers copied to button bytes
    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SAMPLE7, S_CLK_HI, S_CLK_LO, S_COMMIT
    } state_t;

    localparam int            CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sr1_q, sr1_d, sr2_q, sr2_d;
    logic [7:0]    btn1_q, btn1_d, btn2_q, btn2_d;
    logic          clk_q, latch_q;
    logic          tick;
    logic          sel1, sel2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr1_d   = sr1_q;
        sr2_d   = sr2_q;
        btn1_d  = btn1_q;
        btn2_d  = btn2_q;
        tick    = (cnt_q == '0);

        // down-counter reloads on terminal count while a tick-timed state is active
        if (state_q == S_LATCH || state_q == S_SAMPLE7 ||
            state_q == S_CLK_HI || state_q == S_CLK_LO) begin
            cnt_d = tick ? TICK_LAST : cnt_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LATCH;
                    cnt_d   = TICK_LAST;
                end
            end
            S_LATCH: begin
                if (tick) state_d = S_SAMPLE7;
            end
            S_SAMPLE7: begin
                if (tick) begin
                    sr1_d   = {sr1_q[6:0], ~controller_1_data_in_B};
                    sr2_d   = {sr2_q[6:0], ~controller_2_data_in_B};
                    bit_d   = 3'd6;
                    state_d = S_CLK_HI;
                end
            end
            S_CLK_HI: begin
                if (tick) begin
                    sr1_d   = {sr1_q[6:0], ~controller_1_data_in_B};
                    sr2_d   = {sr2_q[6:0], ~controller_2_data_in_B};
                    state_d = S_CLK_LO;
                end
            end
            S_CLK_LO: begin
                if (tick) begin
                    if (bit_q == 3'd0) begin
                        state_d = S_COMMIT;
                    end else begin
                        bit_d   = bit_q - 3'd1;
                        state_d = S_CLK_HI;
                    end
                end
            end
            S_COMMIT: begin
                btn1_d  = sr1_q;
                btn2_d  = sr2_q;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr1_q   <= '0;
            sr2_q   <= '0;
            btn1_q  <= '0;
            btn2_q  <= '0;
            clk_q   <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr1_q   <= sr1_d;
            sr2_q   <= sr2_d;
            btn1_q  <= btn1_d;
            btn2_q  <= btn2_d;
            // pin drivers registered so the shared lines never glitch
            clk_q   <= (state_d == S_CLK_HI);
            latch_q <= (state_d == S_LATCH);
        end
    end

    assign sel1 = (cpu_address == CTRL1_ADDR);
    assign sel2 = (cpu_address == CTRL2_ADDR);

    always_comb begin
        data_out = 8'h00;
        if (write_enable_B) begin
            if (sel1)      data_out = btn1_q;
            else if (sel2) data_out = btn2_q;
        end
    end

    assign fpga_data_enable      = write_enable_B && (sel1 || sel2);
    assign controller_clk        = clk_q;
    assign controller_latch      = latch_q;
    assign controller_1_data_out = btn1_q;
    assign controller_2_data_out = btn2_q;
    assign busy                  = (state_q != S_IDLE);

endmodule

// File: tb/tb_controller_interface.sv
// Scoreboard bench for controller_interface: behavioural 4021 controllers,
// poll/read expectations queued by stimulus and checked by a monitor.
module tb_controller_interface;
    localparam int TD       = 12;
    localparam int POLL_LEN = 16 * TD + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cpu_address = 16'h0000;
    logic        write_enable_B = 1'b1;
    logic [7:0]  data_out;
    logic        fpga_data_enable;
    logic        controller_clk, controller_latch;
    logic        c1_b, c2_b;
    logic [7:0]  c1_out, c2_out;
    logic        busy;

    controller_interface #(
        .TICK_DIV(TD), .CTRL1_ADDR(16'h7002), .CTRL2_ADDR(16'h7003)
    ) dut (
        .clk_12_5875(clk),
        .rst(rst),
        .start(start),
        .cpu_address(cpu_address),
        .write_enable_B(write_enable_B),
        .data_out(data_out),
        .fpga_data_enable(fpga_data_enable),
        .controller_clk(controller_clk),
        .controller_latch(controller_latch),
        .controller_1_data_in_B(c1_b),
        .controller_2_data_in_B(c2_b),
        .controller_1_data_out(c1_out),
        .controller_2_data_out(c2_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // 4021-style controllers: parallel load while latch high, shift on rising clk
    logic [7:0] btn1 = 8'h00, btn2 = 8'h00;
    logic [7:0] sh1 = 8'h00, sh2 = 8'h00;
    logic       cclk_prev = 1'b0;
    always @(posedge clk) begin
        cclk_prev <= controller_clk;
        if (controller_latch) begin
            sh1 <= btn1;
            sh2 <= btn2;
        end else if (controller_clk && !cclk_prev) begin
            sh1 <= {sh1[6:0], 1'b0};
            sh2 <= {sh2[6:0], 1'b0};
        end
    end
    assign c1_b = ~sh1[7];
    assign c2_b = ~sh2[7];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [7:0] c1;
        logic [7:0] c2;
        int         t0;
    } poll_t;
    poll_t      poll_q[$];
    logic [7:0] rd_q[$];

    // monitor: pops expectations when a poll completes or a read is presented
    initial begin
        logic busy_prev = 1'b0, latch_prev = 1'b0, cclk_p = 1'b0;
        int   lw = 0, cw = 0, nl = 0, nc = 0;
        poll_t p;
        forever begin
            @(negedge clk);
            if (busy && !busy_prev) begin
                nl = 0;
                nc = 0;
            end
            if (controller_latch && !latch_prev) nl++;
            if (controller_clk && !cclk_p) nc++;
            if (rst) begin
                lw = 0;
                cw = 0;
            end else begin
                if (controller_latch) lw++;
                else if (lw != 0) begin chk("latch_width", lw, TD); lw = 0; end
                if (controller_clk) cw++;
                else if (cw != 0) begin chk("cclk_width", cw, TD); cw = 0; end
            end
            if (busy_prev && !busy && !rst) begin
                if (poll_q.size() == 0) chk("unexpected_poll_end", 1, 0);
                else begin
                    p = poll_q.pop_front();
                    chk("poll_c1", c1_out, p.c1);
                    chk("poll_c2", c2_out, p.c2);
                    chk("poll_len", cyc - p.t0, POLL_LEN);
                    chk("latch_pulses", nl, 1);
                    chk("cclk_pulses", nc, 7);
                end
            end
            if (fpga_data_enable) begin
                if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
                else chk("read_data", data_out, rd_q.pop_front());
            end
            busy_prev  = busy;
            latch_prev = controller_latch;
            cclk_p     = controller_clk;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] e1, input logic [7:0] e2, input bit expect_it);
        poll_t p;
        if (expect_it) begin
            p.c1 = e1;
            p.c2 = e2;
            p.t0 = cyc + 1;
            poll_q.push_back(p);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_access(input logic [15:0] a, input logic we_b,
                             input logic exp_en, input logic [7:0] exp_d);
        cpu_address    = a;
        write_enable_B = we_b;
        if (exp_en) rd_q.push_back(exp_d);
        #1;
        chk("enable", fpga_data_enable, exp_en);
        if (!exp_en) chk("data_idle", data_out, 8'h00);
        step(1);
        cpu_address    = 16'h0000;
        write_enable_B = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench timed out");
        $fatal(1);
    end

    initial begin
        btn1 = 8'b1000_1001;
        btn2 = 8'b0010_0110;
        step(3);
        chk("rst_c1", c1_out, 8'h00);
        chk("rst_c2", c2_out, 8'h00);
        chk("rst_latch", controller_latch, 1'b0);
        chk("rst_cclk", controller_clk, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_enable", fpga_data_enable, 1'b0);
        rst = 1'b0;
        step(2);

        do_start(8'h89, 8'h26, 1'b1);
        step(POLL_LEN + 4);
        chk("poll1_busy", busy, 1'b0);

        do_access(16'h7003, 1'b1, 1'b1, 8'h26);
        do_access(16'h7002, 1'b1, 1'b1, 8'h89);
        do_access(16'h7004, 1'b1, 1'b0, 8'h00);
        do_access(16'h7002, 1'b0, 1'b0, 8'h00);
        chk("write_ignored", c1_out, 8'h89);

        // second poll: buttons change after latch, extra start at tick 5
        do_start(8'h89, 8'h26, 1'b1);
        step(3 * TD);
        btn1 = 8'h40;
        chk("hold_mid_poll", c1_out, 8'h89);
        step(2 * TD);
        do_start(8'h00, 8'h00, 1'b0);
        step(9 * TD);
        chk("hold_late_poll", c1_out, 8'h89);
        step(POLL_LEN);

        do_start(8'h40, 8'h26, 1'b1);
        step(POLL_LEN + 4);
        do_access(16'h7002, 1'b1, 1'b1, 8'h40);

        // abort a poll with reset at tick 8
        btn1 = 8'h5A;
        btn2 = 8'hC3;
        do_start(8'h00, 8'h00, 1'b0);
        step(8 * TD);
        rst = 1'b1;
        step(1);
        chk("abort_c1", c1_out, 8'h00);
        chk("abort_c2", c2_out, 8'h00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_latch", controller_latch, 1'b0);
        chk("abort_cclk", controller_clk, 1'b0);
        step(1);
        rst = 1'b0;
        step(2);

        do_start(8'h5A, 8'hC3, 1'b1);
        step(POLL_LEN + 4);
        do_access(16'h7003, 1'b1, 1'b1, 8'hC3);
        step(2);

        chk("polls_drained", poll_q.size(), 0);
        chk("reads_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
